stopwatch_core: RTL and testbench
=================================

Name: stopwatch_core

Overview:
- Consumer end of the divided-clock interface: takes the slow square-wave outputs of the stopwatch clock divider (clk_1hz, clk_2hz, clk_400hz, all generated from sclk) and recovers one-cycle sclk ticks from their rising edges.
- Uses the ticks to run an MM:SS stopwatch with pause and per-field adjust.
- Drives a 4-digit multiplexed seven-segment display.
- Sits between the clock divider and the board display pins.

Parameters:
- MAX_MIN, 59, highest minutes value; minutes wrap from MAX_MIN to 0. Legal range 9..59.

Ports:
- sclk  input  1  system clock; single clock domain.
- rst_n  input  1  synchronous, active-low reset.
- clk_1hz  input  1  divider output, 50% square wave, synchronous to sclk.
- clk_2hz  input  1  divider output, 50% square wave, synchronous to sclk.
- clk_400hz  input  1  divider output, 50% square wave, synchronous to sclk.
- pause_p  input  1  debounced single-cycle pause/resume pulse.
- adj  input  1  level; 1 = adjust mode.
- sel  input  1  level; adjust field select: 0 = minutes, 1 = seconds.
- seg  output  8  cathodes, active-low, bit order {dp,g,f,e,d,c,b,a}; dp is always 1.
- an  output  4  anodes, active-low, one-hot-low.
- state  output  2  00 = RUN, 01 = PAUSED, 10 = ADJUST.

Behaviour:
- Reset is sampled on the sclk edge only; there is no asynchronous path.
  - During reset, the edge-detect history registers load the current clk_* input values, so no spurious tick occurs after reset is released.
  - Reset values: min=00, sec=00, state=RUN, saved_paused=0, digit index=0, an=4'b1110, seg=8'hC0.
- Tick recovery: tick_x = clk_x & ~clk_x_q, where clk_x_q is clk_x registered.
  - Each tick is exactly 1 sclk cycle.
  - The tick fires in the cycle after the input rises.
- Time storage: four BCD digits (min_tens, min_ones, sec_tens, sec_ones).
- RUN:
  - On tick_1hz, sec increments.
  - sec 59 -> 00 carries into min.
  - min MAX_MIN -> 00, so 59:59 -> 00:00.
  - No overflow flag.
- PAUSED: time holds; tick_1hz is ignored.
- ADJUST:
  - tick_1hz is ignored.
  - On tick_2hz, the selected field increments by 1.
  - seconds wrap 59 -> 00 with no carry; minutes wrap MAX_MIN -> 00.
  - sel may change at any time and takes effect the same cycle.
- State transitions (registered, effective the next cycle):
  - RUN + pause_p -> PAUSED.
  - PAUSED + pause_p -> RUN.
  - RUN/PAUSED + adj=1 -> ADJUST; saved_paused records whether the prior state was PAUSED.
  - ADJUST + adj=0 -> PAUSED if saved_paused, else RUN.
  - pause_p is ignored in ADJUST.
- Simultaneous events:
  - Any tick arriving in the same cycle as a state change is applied under the current (old) state.
  - pause_p and adj=1 in the same cycle: adj wins, and saved_paused takes the toggled value.
- Display scan:
  - A 2-bit digit index advances on tick_400hz, giving 400 digit updates/s (100 Hz refresh per digit).
  - Digit map: idx0 = an[0] = sec_ones, idx1 = an[1] = sec_tens, idx2 = an[2] = min_ones, idx3 = an[3] = min_tens.
  - an and seg are registered; both reflect a new index or a new digit value 1 cycle after it changes.
- Blink: in ADJUST, while clk_2hz is low, the digits of the selected field are blanked: an bits = 1 and seg = 8'hFF. Other digits display normally.
- Encoding (active-low): 0=C0, 1=F9, 2=A4, 3=B0, 4=99, 5=92, 6=82, 7=F8, 8=80, 9=90.
- Reset asserted mid-operation: all registers take their reset values on that edge, regardless of state or pending ticks.

Test Plan:
- The bench drives the clk_* inputs directly as slow square waves with short periods, e.g. 1hz = 40 cycles, 2hz = 20, 400hz = 4.
- Reset/tick recovery: hold clk_1hz=1 across reset release -> no sec increment until the next 0->1 edge; an=1110, seg=C0 after reset; each rising edge gives exactly one increment.
- Carry/wrap: preload to 00:58 by adjust, run 2 tick_1hz -> 01:00; from 59:59 one tick_1hz -> 00:00.
- Pause: pause_p at 00:05 -> state=01, 3 tick_1hz pulses leave 00:05; a second pause_p -> state=00, next tick gives 00:06; pause_p coincident with a tick at 00:06 -> 00:07, then paused.
- Adjust: from PAUSED at 00:00, adj=1 and sel=1, 61 tick_2hz -> 00:01 with minutes unchanged (wrap without carry); adj=0 -> state=01; tick_1hz ignored while in ADJUST.
- Display: time 12:34, run the scan over 4 tick_400hz -> an/seg pairs 1110/99, 1101/B0, 1011/A4, 0111/F9; in ADJUST with sel=0 and clk_2hz low, an[3:2] are high and seg=FF on those slots.
- Mid-operation reset: rst_n=0 for 1 cycle during ADJUST at 07:42 -> next cycle 00:00, state=00, an=1110.

Source files
------------

// File: rtl/stopwatch_core.sv
// MM:SS stopwatch driven by divider square waves, with pause, per-field
// adjust and a 4-digit multiplexed seven-segment scan.
module stopwatch_core #(
  parameter int unsigned MAX_MIN = 59
) (
  input  logic       sclk,
  input  logic       rst_n,
  input  logic       clk_1hz,
  input  logic       clk_2hz,
  input  logic       clk_400hz,
  input  logic       pause_p,
  input  logic       adj,
  input  logic       sel,
  output logic [7:0] seg,
  output logic [3:0] an,
  output logic [1:0] state
);

  typedef enum logic [1:0] {
    S_RUN    = 2'b00,
    S_PAUSED = 2'b01,
    S_ADJUST = 2'b10
  } state_t;

  localparam logic [3:0] MAX_T = 4'(MAX_MIN / 10);
  localparam logic [3:0] MAX_O = 4'(MAX_MIN % 10);

  state_t     cur, nxt;
  logic       saved_paused, saved_nx;
  logic       clk_1hz_q, clk_2hz_q, clk_400hz_q;
  logic       tick_1hz, tick_2hz, tick_400hz;
  logic [3:0] min_tens, min_ones, sec_tens, sec_ones;
  logic [3:0] min_tens_inc, min_ones_inc, sec_tens_inc, sec_ones_inc;
  logic       sec_wrap;
  logic [1:0] idx;
  logic [3:0] digit;
  logic       blank;

  // History registers load the live inputs both in and out of reset, so
  // the reset branch collapses into the normal path.
  always_ff @(posedge sclk) begin
    clk_1hz_q   <= clk_1hz;
    clk_2hz_q   <= clk_2hz;
    clk_400hz_q <= clk_400hz;
  end

  assign tick_1hz   = clk_1hz   & ~clk_1hz_q;
  assign tick_2hz   = clk_2hz   & ~clk_2hz_q;
  assign tick_400hz = clk_400hz & ~clk_400hz_q;

  // Incremented field values with wrap
  always_comb begin
    sec_wrap     = (sec_tens == 4'd5) && (sec_ones == 4'd9);
    sec_ones_inc = sec_ones + 4'd1;
    sec_tens_inc = sec_tens;
    if (sec_ones == 4'd9) begin
      sec_ones_inc = '0;
      sec_tens_inc = (sec_tens == 4'd5) ? 4'd0 : sec_tens + 4'd1;
    end
    min_ones_inc = min_ones + 4'd1;
    min_tens_inc = min_tens;
    if ((min_tens == MAX_T) && (min_ones == MAX_O)) begin
      min_ones_inc = '0;
      min_tens_inc = '0;
    end else if (min_ones == 4'd9) begin
      min_ones_inc = '0;
      min_tens_inc = min_tens + 4'd1;
    end
  end

  // Next state and saved pause flag
  always_comb begin
    nxt      = cur;
    saved_nx = saved_paused;
    unique case (cur)
      S_RUN: begin
        if (adj) begin
          nxt      = S_ADJUST;
          saved_nx = pause_p;
        end else if (pause_p) begin
          nxt = S_PAUSED;
        end
      end
      S_PAUSED: begin
        if (adj) begin
          nxt      = S_ADJUST;
          saved_nx = ~pause_p;
        end else if (pause_p) begin
          nxt = S_RUN;
        end
      end
      S_ADJUST: begin
        if (!adj) nxt = saved_paused ? S_PAUSED : S_RUN;
      end
      default: nxt = S_RUN;
    endcase
  end

  // State register
  always_ff @(posedge sclk) begin
    if (!rst_n) begin
      cur          <= S_RUN;
      saved_paused <= 1'b0;
    end else begin
      cur          <= nxt;
      saved_paused <= saved_nx;
    end
  end

  // Time digits; ticks act under the pre-transition state
  always_ff @(posedge sclk) begin
    if (!rst_n) begin
      min_tens <= '0;
      min_ones <= '0;
      sec_tens <= '0;
      sec_ones <= '0;
    end else if ((cur == S_RUN) && tick_1hz) begin
      sec_tens <= sec_tens_inc;
      sec_ones <= sec_ones_inc;
      if (sec_wrap) begin
        min_tens <= min_tens_inc;
        min_ones <= min_ones_inc;
      end
    end else if ((cur == S_ADJUST) && tick_2hz) begin
      if (sel) begin
        sec_tens <= sec_tens_inc;
        sec_ones <= sec_ones_inc;
      end else begin
        min_tens <= min_tens_inc;
        min_ones <= min_ones_inc;
      end
    end
  end

  // Scan index
  always_ff @(posedge sclk) begin
    if (!rst_n)          idx <= '0;
    else if (tick_400hz) idx <= idx + 2'd1;
  end

  // Digit select and blink
  always_comb begin
    unique case (idx)
      2'd0:    digit = sec_ones;
      2'd1:    digit = sec_tens;
      2'd2:    digit = min_ones;
      default: digit = min_tens;
    endcase
    blank = (cur == S_ADJUST) && !clk_2hz && (sel ? !idx[1] : idx[1]);
  end

  function automatic logic [7:0] seg_enc(input logic [3:0] d);
    unique case (d)
      4'd0:    seg_enc = 8'hC0;
      4'd1:    seg_enc = 8'hF9;
      4'd2:    seg_enc = 8'hA4;
      4'd3:    seg_enc = 8'hB0;
      4'd4:    seg_enc = 8'h99;
      4'd5:    seg_enc = 8'h92;
      4'd6:    seg_enc = 8'h82;
      4'd7:    seg_enc = 8'hF8;
      4'd8:    seg_enc = 8'h80;
      4'd9:    seg_enc = 8'h90;
      default: seg_enc = 8'hFF;
    endcase
  endfunction

  // Registered display outputs
  always_ff @(posedge sclk) begin
    if (!rst_n) begin
      an  <= 4'b1110;
      seg <= 8'hC0;
    end else if (blank) begin
      an  <= '1;
      seg <= '1;
    end else begin
      an  <= ~(4'b0001 << idx);
      seg <= seg_enc(digit);
    end
  end

  assign state = cur;

endmodule

// File: tb/tb_stopwatch_core.sv
module tb_stopwatch_core;

  localparam int MAXM = 59;
  localparam int P1 = 40, P2 = 20, P4 = 4;

  logic       sclk = 1'b0;
  logic       rst_n, clk_1hz, clk_2hz, clk_400hz, pause_p, adj, sel;
  logic [7:0] seg;
  logic [3:0] an;
  logic [1:0] state;

  stopwatch_core #(.MAX_MIN(MAXM)) dut (
    .sclk(sclk), .rst_n(rst_n), .clk_1hz(clk_1hz), .clk_2hz(clk_2hz),
    .clk_400hz(clk_400hz), .pause_p(pause_p), .adj(adj), .sel(sel),
    .seg(seg), .an(an), .state(state)
  );

  always #5 sclk = ~sclk;

  int n_checks = 0;
  int n_errors = 0;

  // Stimulus controls
  int unsigned cyc = 1000;
  int unsigned o1, o2, o4;
  logic rst_v = 1'b0, pause_v = 1'b0, adj_v = 1'b0, sel_v = 1'b0;

  // Reference model: time as plain integers, state as 0/1/2
  int m_sec, m_min, m_st, m_saved, m_idx;
  logic [3:0] m_an;
  logic [7:0] m_seg;
  logic m_p1, m_p2, m_p4;
  logic [7:0] enc [10] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99,
                           8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h cyc=%0d time=%02d:%02d", tag, got, exp, cyc, m_min, m_sec);
    end
  endtask

  function automatic logic wave(input int unsigned c, input int unsigned per);
    return (c % per) >= (per / 2);
  endfunction

  task automatic model_edge();
    logic t1, t2, t4, blank;
    int d;
    if (!rst_v) begin
      m_sec = 0; m_min = 0; m_st = 0; m_saved = 0; m_idx = 0;
      m_an = 4'b1110; m_seg = 8'hC0;
    end else begin
      case (m_idx)
        0: d = m_sec % 10;
        1: d = m_sec / 10;
        2: d = m_min % 10;
        default: d = m_min / 10;
      endcase
      blank = (m_st == 2) && !clk_2hz && (sel_v ? (m_idx < 2) : (m_idx >= 2));
      m_an  = blank ? 4'hF : ~(4'(1) << m_idx);
      m_seg = blank ? 8'hFF : enc[d];
      t1 = clk_1hz & ~m_p1;
      t2 = clk_2hz & ~m_p2;
      t4 = clk_400hz & ~m_p4;
      if (m_st == 0 && t1) begin
        m_sec++;
        if (m_sec == 60) begin
          m_sec = 0;
          m_min = (m_min == MAXM) ? 0 : m_min + 1;
        end
      end else if (m_st == 2 && t2) begin
        if (sel_v) m_sec = (m_sec + 1) % 60;
        else       m_min = (m_min == MAXM) ? 0 : m_min + 1;
      end
      if (t4) m_idx = (m_idx + 1) % 4;
      if (m_st != 2) begin
        if (adj_v) begin
          m_saved = (m_st == 1) ^ pause_v;
          m_st = 2;
        end else if (pause_v) begin
          m_st = (m_st == 0) ? 1 : 0;
        end
      end else if (!adj_v) begin
        m_st = m_saved ? 1 : 0;
      end
    end
    m_p1 = clk_1hz; m_p2 = clk_2hz; m_p4 = clk_400hz;
  endtask

  task automatic step();
    clk_1hz   = wave(cyc + o1, P1);
    clk_2hz   = wave(cyc + o2, P2);
    clk_400hz = wave(cyc + o4, P4);
    rst_n = rst_v; pause_p = pause_v; adj = adj_v; sel = sel_v;
    @(posedge sclk);
    model_edge();
    #1;
    chk("state", 32'(state), 32'(m_st));
    chk("an", 32'(an), 32'(m_an));
    chk("seg", 32'(seg), 32'(m_seg));
    @(negedge sclk);
    cyc++;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic pulse_pause();
    pause_v = 1'b1; step(); pause_v = 1'b0;
  endtask

  task automatic adjust_to(input int tm, input int ts);
    int g;
    adj_v = 1'b1; sel_v = 1'b0;
    g = 0;
    while (m_min != tm && g < 2000) begin step(); g++; end
    chk("adj_min_reached", 32'(m_min), 32'(tm));
    sel_v = 1'b1;
    g = 0;
    while (m_sec != ts && g < 2000) begin step(); g++; end
    chk("adj_sec_reached", 32'(m_sec), 32'(ts));
  endtask

  initial begin
    int g;
    o1 = $urandom_range(0, P1 - 1);
    o2 = $urandom_range(0, P2 - 1);
    o4 = $urandom_range(0, P4 - 1);

    // Reset, released while clk_1hz is held high
    rst_v = 1'b0;
    run(3);
    chk("rst_an", 32'(an), 32'h0000_000E);
    chk("rst_seg", 32'(seg), 32'h0000_00C0);
    chk("rst_state", 32'(state), 32'h0);
    g = 0;
    while (!(wave(cyc + o1, P1) && wave(cyc + o1 + 8, P1)) && g < 100) begin step(); g++; end
    rst_v = 1'b1;
    run(8 * P1 + 5);

    // Pause, hold, resume
    pulse_pause();
    run(3 * P1 + 7);
    pulse_pause();
    run(P1 + 3);

    // Pause coincident with a 1 Hz tick
    g = 0;
    while (!(wave(cyc + o1, P1) && !wave(cyc + o1 - 1, P1)) && g < 100) begin step(); g++; end
    pulse_pause();
    run(2 * P1);

    // Adjust seconds from PAUSED: 61 ticks wrap without carry
    adj_v = 1'b1; sel_v = 1'b1;
    run(61 * P2 + 3);
    adj_v = 1'b0;
    run(P1 + 4);

    // Carry 00:58 -> 01:00
    adjust_to(0, 58);
    adj_v = 1'b0;
    run(3 * P1);
    if (m_st == 1) pulse_pause();
    run(2 * P1 + 5);

    // 59:59 -> 00:00
    adjust_to(59, 59);
    adj_v = 1'b0;
    run(2 * P1);
    if (m_st == 1) pulse_pause();
    run(2 * P1);

    // Display at 12:34, then blink of the minutes field
    adjust_to(12, 34);
    adj_v = 1'b0;
    run(3);
    if (m_st == 0) pulse_pause();
    run(5 * P4);
    adj_v = 1'b1; sel_v = 1'b0;
    run(2 * P2);
    sel_v = 1'b1;
    run(2 * P2);

    // Reset mid-adjust at 07:42
    adjust_to(7, 42);
    rst_v = 1'b0; adj_v = 1'b0;
    step();
    rst_v = 1'b1;
    chk("midrst_state", 32'(state), 32'h0);
    chk("midrst_an", 32'(an), 32'h0000_000E);
    chk("midrst_seg", 32'(seg), 32'h0000_00C0);
    run(2 * P1);

    // Random traffic
    for (int i = 0; i < 20000; i++) begin
      pause_v = ($urandom_range(0, 59) == 0);
      if ($urandom_range(0, 299) == 0) adj_v = ~adj_v;
      if ($urandom_range(0, 39) == 0)  sel_v = 1'($urandom);
      rst_v = ($urandom_range(0, 4999) != 0);
      step();
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
